// File: rtl/cnt_dis_min_sec.sv
// Minutes:seconds BCD counter with 7-segment display and button-driven set mode.
// RUN counts on ce; SET_MIN / SET_SEC let btn_inc adjust one field mod 60.
// carry_out pulses one cycle after 59:59 wraps to 00:00 (feeds the hour stage).
// Optional macro CNT_DIS_BLINK_EN adds a blink phase that blanks the field being set.
//
// Button handshake: btn_mode / btn_inc are asynchronous levels. Each passes through
// two synchroniser flops and a rising-edge detector, so the action lands on the
// third rising clk edge that samples the button high. Holding a button gives one pulse.
module cnt_dis_min_sec (
  input  logic       clk,
  input  logic       glob_rst_n,
  input  logic       ce,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       carry_out,
  output logic [6:0] seg3,
  output logic [6:0] seg2,
  output logic [6:0] seg1,
  output logic [6:0] seg0,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_MIN = 2'b01,
    ST_SET_SEC = 2'b10
  } state_e;

  state_e     r_state;
  state_e     w_state_nxt;
  logic [2:0] r_mode_sync;
  logic [2:0] r_inc_sync;
  logic [3:0] r_sec_u;
  logic [3:0] r_sec_t;
  logic [3:0] r_min_u;
  logic [3:0] r_min_t;
  logic       r_carry;
  logic       w_mode_pulse;
  logic       w_inc_pulse;
  logic       w_run_tick;
  logic       w_sec_wrap;
  logic       w_min_wrap;
  logic       w_sec_step;
  logic       w_min_step;
  logic       w_blank_min;
  logic       w_blank_sec;

  // Bit 0/1 are the synchroniser, bit 2 remembers the previous synchronised level.
  always_ff @(posedge clk or negedge glob_rst_n) begin
    if (!glob_rst_n) begin
      r_mode_sync <= 3'b000;
      r_inc_sync  <= 3'b000;
    end else begin
      r_mode_sync <= {r_mode_sync[1:0], btn_mode};
      r_inc_sync  <= {r_inc_sync[1:0], btn_inc};
    end
  end

  assign w_mode_pulse = r_mode_sync[1] & ~r_mode_sync[2];
  assign w_inc_pulse  = r_inc_sync[1] & ~r_inc_sync[2];

  // FSM state register.
  always_ff @(posedge clk or negedge glob_rst_n) begin
    if (!glob_rst_n) r_state <= ST_RUN;
    else             r_state <= w_state_nxt;
  end

  // Mode button cycles RUN -> SET_MIN -> SET_SEC -> RUN; the unused code returns to RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:     if (w_mode_pulse) w_state_nxt = ST_SET_MIN;
      ST_SET_MIN: if (w_mode_pulse) w_state_nxt = ST_SET_SEC;
      ST_SET_SEC: if (w_mode_pulse) w_state_nxt = ST_RUN;
      default:    w_state_nxt = ST_RUN;
    endcase
  end

  assign mode = r_state;

  // An inc pulse coinciding with a mode pulse is dropped; ce only counts in RUN.
  assign w_run_tick = (r_state == ST_RUN) && ce;
  assign w_sec_wrap = (r_sec_t == 4'd5) && (r_sec_u == 4'd9);
  assign w_min_wrap = (r_min_t == 4'd5) && (r_min_u == 4'd9);
  assign w_sec_step = w_run_tick ||
                      ((r_state == ST_SET_SEC) && w_inc_pulse && !w_mode_pulse);
  assign w_min_step = (w_run_tick && w_sec_wrap) ||
                      ((r_state == ST_SET_MIN) && w_inc_pulse && !w_mode_pulse);

  // Seconds field, BCD modulo 60.
  always_ff @(posedge clk or negedge glob_rst_n) begin
    if (!glob_rst_n) begin
      r_sec_u <= 4'd0;
      r_sec_t <= 4'd0;
    end else if (w_sec_step) begin
      if (w_sec_wrap) begin
        r_sec_u <= 4'd0;
        r_sec_t <= 4'd0;
      end else if (r_sec_u == 4'd9) begin
        r_sec_u <= 4'd0;
        r_sec_t <= r_sec_t + 4'd1;
      end else begin
        r_sec_u <= r_sec_u + 4'd1;
      end
    end
  end

  // Minutes field, BCD modulo 60.
  always_ff @(posedge clk or negedge glob_rst_n) begin
    if (!glob_rst_n) begin
      r_min_u <= 4'd0;
      r_min_t <= 4'd0;
    end else if (w_min_step) begin
      if (w_min_wrap) begin
        r_min_u <= 4'd0;
        r_min_t <= 4'd0;
      end else if (r_min_u == 4'd9) begin
        r_min_u <= 4'd0;
        r_min_t <= r_min_t + 4'd1;
      end else begin
        r_min_u <= r_min_u + 4'd1;
      end
    end
  end

  // Carry is registered: high in the cycle after 59:59 rolls to 00:00 while counting.
  always_ff @(posedge clk or negedge glob_rst_n) begin
    if (!glob_rst_n) r_carry <= 1'b0;
    else             r_carry <= w_run_tick && w_sec_wrap && w_min_wrap;
  end

  assign carry_out = r_carry;

`ifdef CNT_DIS_BLINK_EN
  logic r_phase;

  // Blink phase toggles on every ce regardless of state.
  always_ff @(posedge clk or negedge glob_rst_n) begin
    if (!glob_rst_n) r_phase <= 1'b0;
    else if (ce)     r_phase <= ~r_phase;
  end

  assign w_blank_min = r_phase && (r_state == ST_SET_MIN);
  assign w_blank_sec = r_phase && (r_state == ST_SET_SEC);
`else
  assign w_blank_min = 1'b0;
  assign w_blank_sec = 1'b0;
`endif

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes show blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign seg3 = w_blank_min ? 7'b1111111 : seg7(r_min_t);
  assign seg2 = w_blank_min ? 7'b1111111 : seg7(r_min_u);
  assign seg1 = w_blank_sec ? 7'b1111111 : seg7(r_sec_t);
  assign seg0 = w_blank_sec ? 7'b1111111 : seg7(r_sec_u);

endmodule

// File: tb/tb_cnt_dis_min_sec.sv
// Bench for cnt_dis_min_sec: table of operations with expected display/mode,
// followed by hand-written sequences for carry, held button, simultaneous
// buttons, asynchronous reset and blink phase.
module tb_cnt_dis_min_sec;

  logic       clk = 1'b0;
  logic       glob_rst_n;
  logic       ce;
  logic       btn_mode;
  logic       btn_inc;
  logic       carry_out;
  logic [6:0] seg3, seg2, seg1, seg0;
  logic [1:0] mode;

  int   checks = 0;
  int   errors = 0;
  int   carry_cnt = 0;
  logic exp_phase = 1'b0;
  logic [6:0] seg_tab [10];

  typedef enum int {OP_CE, OP_MODE, OP_INC} op_e;
  typedef struct {
    op_e        op;
    int         n;
    int         m;
    int         s;
    logic [1:0] md;
  } vec_t;
  vec_t vecs [17];

  cnt_dis_min_sec dut (
    .clk        (clk),
    .glob_rst_n (glob_rst_n),
    .ce         (ce),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .carry_out  (carry_out),
    .seg3       (seg3),
    .seg2       (seg2),
    .seg1       (seg1),
    .seg0       (seg0),
    .mode       (mode)
  );

  // Clock.
  always #5 clk = ~clk;

  // Count carry pulses: each high cycle is seen once at the edge that ends it.
  always @(posedge clk) if (carry_out === 1'b1) carry_cnt++;

  function automatic logic [29:0] exp_disp(input int m, input int s, input logic [1:0] md);
    logic [6:0] e3, e2, e1, e0;
    e3 = seg_tab[m / 10];
    e2 = seg_tab[m % 10];
    e1 = seg_tab[s / 10];
    e0 = seg_tab[s % 10];
`ifdef CNT_DIS_BLINK_EN
    if (exp_phase && md == 2'b01) begin e3 = 7'b1111111; e2 = 7'b1111111; end
    if (exp_phase && md == 2'b10) begin e1 = 7'b1111111; e0 = 7'b1111111; end
`endif
    return {e3, e2, e1, e0, md};
  endfunction

  task automatic check_disp(input string name, input int m, input int s, input logic [1:0] md);
    logic [29:0] got, exp;
    got = {seg3, seg2, seg1, seg0, mode};
    exp = exp_disp(m, s, md);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got seg/mode %b, expected %b (%02d:%02d mode %0d)", name, got, exp, m, s, md);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_seg(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  // Driver tasks: inputs change on the falling edge.
  task automatic pulse_ce();
    ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
    exp_phase = ~exp_phase;
  endtask

  task automatic press(input logic m, input logic i, input int hold);
    btn_mode = m;
    btn_inc  = i;
    repeat (hold) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_op(input op_e op, input int n);
    for (int k = 0; k < n; k++) begin
      case (op)
        OP_CE:   pulse_ce();
        OP_MODE: press(1'b1, 1'b0, 4);
        default: press(1'b0, 1'b1, 4);
      endcase
    end
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;

    vecs[0]  = '{OP_CE,   60,  1,  0, 2'b00};
    vecs[1]  = '{OP_CE,    5,  1,  5, 2'b00};
    vecs[2]  = '{OP_MODE,  1,  1,  5, 2'b01};
    vecs[3]  = '{OP_INC,   2,  3,  5, 2'b01};
    vecs[4]  = '{OP_CE,    3,  3,  5, 2'b01};
    vecs[5]  = '{OP_MODE,  1,  3,  5, 2'b10};
    vecs[6]  = '{OP_INC,  56,  3,  1, 2'b10};
    vecs[7]  = '{OP_CE,    2,  3,  1, 2'b10};
    vecs[8]  = '{OP_MODE,  1,  3,  1, 2'b00};
    vecs[9]  = '{OP_CE,    1,  3,  2, 2'b00};
    vecs[10] = '{OP_MODE,  1,  3,  2, 2'b01};
    vecs[11] = '{OP_INC,  56, 59,  2, 2'b01};
    vecs[12] = '{OP_INC,   1,  0,  2, 2'b01};
    vecs[13] = '{OP_INC,  59, 59,  2, 2'b01};
    vecs[14] = '{OP_MODE,  1, 59,  2, 2'b10};
    vecs[15] = '{OP_INC,  56, 59, 58, 2'b10};
    vecs[16] = '{OP_MODE,  1, 59, 58, 2'b00};

    // Reset.
    glob_rst_n = 1'b0;
    ce = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (2) @(negedge clk);
    check_disp("reset_display", 0, 0, 2'b00);
    check_val("reset_carry", int'(carry_out), 0);
    glob_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_disp("after_reset_release", 0, 0, 2'b00);

    // Table-driven operations.
    for (int v = 0; v < 17; v++) begin
      run_op(vecs[v].op, vecs[v].n);
      repeat (2) @(negedge clk);
      check_disp($sformatf("vec%0d", v), vecs[v].m, vecs[v].s, vecs[v].md);
      check_val($sformatf("vec%0d_carry_cnt", v), carry_cnt, 0);
      if (v == 0) check_seg("sixty_ce_seg2", seg2, 7'b1111001);
    end

    // 59:58 -> 59:59 -> 00:00 with a single-cycle carry.
    pulse_ce();
    check_disp("to_5959", 59, 59, 2'b00);
    check_val("carry_before_wrap", int'(carry_out), 0);
    ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
    exp_phase = ~exp_phase;
    check_val("carry_after_wrap", int'(carry_out), 1);
    check_disp("wrap_0000", 0, 0, 2'b00);
    @(negedge clk);
    check_val("carry_one_cycle", int'(carry_out), 0);
    @(negedge clk);
    check_val("carry_pulse_count", carry_cnt, 1);

    // Mode pulse, then inc held 40 cycles with ce pulses in between.
    press(1'b1, 1'b0, 4);
    btn_inc = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ce = (i % 5 == 0);
      @(negedge clk);
      if (i % 5 == 0) exp_phase = ~exp_phase;
    end
    ce = 1'b0;
    btn_inc = 1'b0;
    repeat (4) @(negedge clk);
    check_disp("held_inc_one_step", 1, 0, 2'b01);

    // Back to RUN, then mode and inc together: only the mode change applies.
    press(1'b1, 1'b0, 4);
    press(1'b1, 1'b0, 4);
    check_disp("back_to_run", 1, 0, 2'b00);
    press(1'b1, 1'b1, 4);
    check_disp("simultaneous_mode_inc", 1, 0, 2'b01);

    // Set 12:34 in SET_SEC, then assert reset between clock edges.
    run_op(OP_INC, 11);
    press(1'b1, 1'b0, 4);
    run_op(OP_INC, 34);
    check_disp("set_1234", 12, 34, 2'b10);
    @(posedge clk);
    #3 glob_rst_n = 1'b0;
    #1 exp_phase = 1'b0;
    check_disp("async_reset_immediate", 0, 0, 2'b00);
    check_val("async_reset_carry", int'(carry_out), 0);
    @(negedge clk);
    glob_rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_disp("after_async_reset", 0, 0, 2'b00);

    // Blink phase in SET_SEC: blank after one ce, visible after the next.
    press(1'b1, 1'b0, 4);
    press(1'b1, 1'b0, 4);
    check_disp("blink_enter_set_sec", 0, 0, 2'b10);
    pulse_ce();
    check_disp("blink_phase1", 0, 0, 2'b10);
`ifdef CNT_DIS_BLINK_EN
    check_seg("blink_seg0_blank", seg0, 7'b1111111);
`else
    check_seg("blink_seg0_shown", seg0, 7'b1000000);
`endif
    pulse_ce();
    check_disp("blink_phase0", 0, 0, 2'b10);
    check_seg("blink_seg0_visible", seg0, 7'b1000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
